// File: rtl/mix_iter.sv
// rtl/mix_iter.sv - iterative BLAKE2 G-function (mix) engine with valid/ready handshakes
//
// Purpose:
//   Takes a 16-word working vector, four word indices (a, b, c, d) and two
//   message words (x, y). It runs the eight G sub-steps, UNROLL of them per
//   clock, and returns the vector with the four mixed words written back.
//   W=64 gives BLAKE2b rotations and W=32 gives BLAKE2s rotations.
//
// Parameters:
//   W       word width, 32 or 64
//   UNROLL  G sub-steps per clock, 1/2/4/8 (N = 8/UNROLL compute cycles)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_ready   engine idle and able to accept a request
//   v          working vector, word i = v[i*W +: W]
//   a,b,c,d    word indices of the G quadruple
//   x, y       message words
//   out_valid  v_out holds a completed result
//   out_ready  consumer accepts the result
//   v_out      registered result vector

module mix_iter #(
  parameter int W      = 64,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [16*W-1:0] v,
  input  logic [3:0]      a,
  input  logic [3:0]      b,
  input  logic [3:0]      c,
  input  logic [3:0]      d,
  input  logic [W-1:0]    x,
  input  logic [W-1:0]    y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [16*W-1:0] v_out
);

  localparam int N  = 8 / UNROLL;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  // BLAKE2b / BLAKE2s rotation amounts
  localparam int R1 = (W == 64) ? 32 : 16;
  localparam int R2 = (W == 64) ? 24 : 12;
  localparam int R3 = (W == 64) ? 16 : 8;
  localparam int R4 = (W == 64) ? 63 : 7;

  generate
    if (W != 32 && W != 64) begin : g_bad_w
      $error("mix_iter: W must be 32 or 64");
    end
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
      $error("mix_iter: UNROLL must be 1, 2, 4 or 8");
    end
  endgenerate

  function automatic logic [W-1:0] rotr(input logic [W-1:0] val, input int r);
    return (val >> r) | (val << (W - r));
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [SW-1:0] step;
  logic          accept;
  logic          last_step;

  // Request unpacked into words so indices can select directly
  logic [W-1:0] v_in [16];

  // Captured request; the inputs are free to change once accepted
  logic [W-1:0] cap_v [16];
  logic [3:0]   cap_a;
  logic [3:0]   cap_b;
  logic [3:0]   cap_c;
  logic [3:0]   cap_d;
  logic [W-1:0] cap_x;
  logic [W-1:0] cap_y;

  // G quadruple registers and their values after this cycle's sub-steps
  logic [W-1:0] ra, rb, rc, rd;
  logic [W-1:0] na, nb, nc, nd;
  logic [2:0]   sub;

  // Write-back view of the vector using this cycle's mixed values
  logic [W-1:0] wb [16];

  assign accept    = in_valid && in_ready;
  assign last_step = (state == S_RUN) && (step == SW'(N - 1));

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      v_in[i] = v[i*W +: W];
    end
  end

  // ---------------------------------------------------------------- FSM

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept)    state_nx = S_RUN;
      S_RUN:  if (last_step) state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default:               state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // ---------------------------------------------------------- datapath

  // Apply this cycle's UNROLL sub-steps in sequence. Each sub-step sees the
  // results of the ones before it in the same cycle, so the in-place
  // blocking updates form the combinational chain.
  always_comb begin
    na  = ra;
    nb  = rb;
    nc  = rc;
    nd  = rd;
    sub = 3'd0;
    for (int j = 0; j < UNROLL; j++) begin
      sub = 3'(int'(step) * UNROLL + j);
      case (sub)
        3'd0: na = na + nb + cap_x;
        3'd1: nd = rotr(nd ^ na, R1);
        3'd2: nc = nc + nd;
        3'd3: nb = rotr(nb ^ nc, R2);
        3'd4: na = na + nb + cap_y;
        3'd5: nd = rotr(nd ^ na, R3);
        3'd6: nc = nc + nd;
        3'd7: nb = rotr(nb ^ nc, R4);
        default: ;
      endcase
    end
  end

  // Writes go in a, b, c, d order so that aliased indices resolve with the
  // later write winning.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      wb[i] = cap_v[i];
    end
    wb[cap_a] = na;
    wb[cap_b] = nb;
    wb[cap_c] = nc;
    wb[cap_d] = nd;
  end

  // Working registers carry no reset: they are always loaded on accept
  // before any use.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 16; i++) begin
        cap_v[i] <= v_in[i];
      end
      cap_a <= a;
      cap_b <= b;
      cap_c <= c;
      cap_d <= d;
      cap_x <= x;
      cap_y <= y;
      ra    <= v_in[a];
      rb    <= v_in[b];
      rc    <= v_in[c];
      rd    <= v_in[d];
    end else if (state == S_RUN) begin
      ra <= na;
      rb <= nb;
      rc <= nc;
      rd <= nd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step  <= '0;
      v_out <= '0;
    end else if (state == S_RUN) begin
      if (last_step) begin
        step <= '0;
        for (int i = 0; i < 16; i++) begin
          v_out[i*W +: W] <= wb[i];
        end
      end else begin
        step <= step + 1'b1;
      end
    end
  end

endmodule
